// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding, debounce default and run-button transition for counter_ctrl.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam int DB_CYCLES_DEF = 4;

  // Run/pause toggling; LOAD never reacts to the run button.
  function automatic state_t run_next(input state_t s);
    case (s)
      ST_IDLE, ST_PAUSE: run_next = ST_RUN;
      ST_RUN:            run_next = ST_PAUSE;
      default:           run_next = s;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF sync, DB_CYCLES stability filter, one-cycle pulse on debounced rise.
// Latency: press pulse DB_CYCLES+2 cycles after a clean rise; no backpressure.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic cp,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample matching the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Button-driven controller for a reversible counter (load/run/pause/direction), registered outputs.
// Latency: action one cycle after a debounced press; optional COUNTER_CTRL_AUTO_REVERSE_EN flips u_ on rco_ fall.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       cp,
  input  logic       rst,
  input  logic       btn_load,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic [3:0] sw,
  input  logic       rco_,
  output logic       ld_,
  output logic       ct_,
  output logic       u_,
  output logic [3:0] D,
  output logic [1:0] state
);

  logic   load_p;
  logic   run_p;
  logic   dir_p;
  logic   rev_p;
  state_t st;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .cp(cp), .rst(rst), .btn(btn_load), .press(load_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .cp(cp), .rst(rst), .btn(btn_run), .press(run_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .cp(cp), .rst(rst), .btn(btn_dir), .press(dir_p)
  );

`ifdef COUNTER_CTRL_AUTO_REVERSE_EN
  logic rco_q;

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      rco_q <= 1'b1;
    end else begin
      rco_q <= rco_;
    end
  end

  assign rev_p = (st == ST_RUN) && rco_q && !rco_;
`else
  logic unused_rco;
  assign unused_rco = rco_;
  assign rev_p      = 1'b0;
`endif

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      st  <= ST_IDLE;
      ld_ <= 1'b1;
      ct_ <= 1'b1;
      u_  <= 1'b0;
      D   <= 4'b0000;
    end else begin
      // OR, not XOR: a dir press coinciding with a carry reversal flips once.
      u_ <= u_ ^ (dir_p | rev_p);
      if (load_p) begin
        st  <= ST_LOAD;
        D   <= sw;
        ld_ <= 1'b0;
        ct_ <= 1'b1;
      end else if (st == ST_LOAD) begin
        st  <= ST_IDLE;
        ld_ <= 1'b1;
        ct_ <= 1'b1;
      end else if (run_p) begin
        st  <= run_next(st);
        ct_ <= (run_next(st) != ST_RUN);
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: debounce timing, FSM transitions, priority and async reset.
module tb_counter_ctrl;

  localparam int DB = 4;

  logic       cp = 1'b0;
  logic       rst = 1'b0;
  logic       btn_load = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_dir = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic       rco_ = 1'b1;
  logic       ld_;
  logic       ct_;
  logic       u_;
  logic [3:0] D;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  counter_ctrl #(.DB_CYCLES(DB)) dut (
    .cp(cp), .rst(rst), .btn_load(btn_load), .btn_run(btn_run), .btn_dir(btn_dir),
    .sw(sw), .rco_(rco_), .ld_(ld_), .ct_(ct_), .u_(u_), .D(D), .state(state)
  );

  always #5 cp = ~cp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic set_btns(input logic l, input logic r, input logic d);
    btn_load = l;
    btn_run  = r;
    btn_dir  = d;
  endtask

  task automatic press(input logic l, input logic r, input logic d, input int hold);
    set_btns(l, r, d);
    repeat (hold) step();
    set_btns(1'b0, 1'b0, 1'b0);
    repeat (DB + 4) step();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (ld_ !== 1'b1) begin bad++; $display("FAIL reset_ld: got %b want 1", ld_); end
    total++; if (ct_ !== 1'b1) begin bad++; $display("FAIL reset_ct: got %b want 1", ct_); end
    total++; if (u_ !== 1'b0) begin bad++; $display("FAIL reset_u: got %b want 0", u_); end
    total++; if (D !== 4'b0000) begin bad++; $display("FAIL reset_D: got %b want 0000", D); end
    repeat (3) @(posedge cp);
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    int lows;
    int first;
    lows  = 0;
    first = -1;
    sw = 4'b0101;
    set_btns(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 10) set_btns(1'b0, 1'b0, 1'b0);
      if (ld_ === 1'b0) begin
        lows++;
        if (first < 0) first = c;
      end
      if (c == DB + 3) begin
        total++; if (state !== 2'd3) begin bad++; $display("FAIL load_state_load: got %0d want 3", state); end
        total++; if (ct_ !== 1'b1) begin bad++; $display("FAIL load_ct_in_load: got %b want 1", ct_); end
      end
    end
    total++; if (lows != 1) begin bad++; $display("FAIL load_ld_pulses: got %0d want 1", lows); end
    total++; if (first != DB + 3) begin bad++; $display("FAIL load_latency: got %0d want %0d", first, DB + 3); end
    total++; if (D !== 4'b0101) begin bad++; $display("FAIL load_D: got %b want 0101", D); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL load_back_idle: got %0d want 0", state); end
    total++; if (ct_ !== 1'b1) begin bad++; $display("FAIL load_ct_idle: got %b want 1", ct_); end
    sw = 4'b1110;
    repeat (3) step();
    total++; if (D !== 4'b0101) begin bad++; $display("FAIL load_D_hold: got %b want 0101", D); end
  endtask

  task automatic test_run();
    set_btns(1'b0, 1'b1, 1'b0);
    repeat (DB - 1) step();
    set_btns(1'b0, 1'b0, 1'b0);
    repeat (10) step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL run_glitch_state: got %0d want 0", state); end
    total++; if (ct_ !== 1'b1) begin bad++; $display("FAIL run_glitch_ct: got %b want 1", ct_); end
    press(1'b0, 1'b1, 1'b0, 8);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL run_first_state: got %0d want 1", state); end
    total++; if (ct_ !== 1'b0) begin bad++; $display("FAIL run_first_ct: got %b want 0", ct_); end
    press(1'b0, 1'b1, 1'b0, 8);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL run_pause_state: got %0d want 2", state); end
    total++; if (ct_ !== 1'b1) begin bad++; $display("FAIL run_pause_ct: got %b want 1", ct_); end
    press(1'b0, 1'b1, 1'b0, 8);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL run_resume_state: got %0d want 1", state); end
    total++; if (ct_ !== 1'b0) begin bad++; $display("FAIL run_resume_ct: got %b want 0", ct_); end
  endtask

  task automatic test_dir();
    set_btns(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == DB + 2) begin
        total++; if (u_ !== 1'b0) begin bad++; $display("FAIL dir_early: got %b want 0", u_); end
      end
      if (c == DB + 3) begin
        total++; if (u_ !== 1'b1) begin bad++; $display("FAIL dir_toggle: got %b want 1", u_); end
        total++; if (ct_ !== 1'b0) begin bad++; $display("FAIL dir_ct_run: got %b want 0", ct_); end
      end
    end
    set_btns(1'b0, 1'b0, 1'b0);
    repeat (DB + 4) step();
    total++; if (u_ !== 1'b1) begin bad++; $display("FAIL dir_hold_single: got %b want 1", u_); end
    press(1'b0, 1'b0, 1'b1, 8);
    total++; if (u_ !== 1'b0) begin bad++; $display("FAIL dir_second: got %b want 0", u_); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL dir_state: got %0d want 1", state); end
  endtask

  task automatic test_load_run_same();
    int seen_run;
    seen_run = 0;
    sw = 4'b1010;
    press(1'b1, 1'b0, 1'b0, 8);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL same_pre_idle: got %0d want 0", state); end
    total++; if (D !== 4'b1010) begin bad++; $display("FAIL same_pre_D: got %b want 1010", D); end
    sw = 4'b0011;
    set_btns(1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 8) set_btns(1'b0, 1'b0, 1'b0);
      if (state === 2'd1) seen_run = 1;
      if (c == DB + 3) begin
        total++; if (state !== 2'd3) begin bad++; $display("FAIL same_load: got %0d want 3", state); end
      end
      if (c == DB + 4) begin
        total++; if (state !== 2'd0) begin bad++; $display("FAIL same_idle: got %0d want 0", state); end
      end
    end
    total++; if (seen_run != 0) begin bad++; $display("FAIL same_no_run: got %0d want 0", seen_run); end
    total++; if (D !== 4'b0011) begin bad++; $display("FAIL same_D: got %b want 0011", D); end
    total++; if (u_ !== 1'b1) begin bad++; $display("FAIL same_dir_applied: got %b want 1", u_); end
  endtask

  task automatic test_rst_mid_load();
    int lows;
    int first;
    lows  = 0;
    first = -1;
    sw = 4'b1111;
    set_btns(1'b1, 1'b0, 1'b0);
    repeat (DB + 3) step();
    total++; if (ld_ !== 1'b0) begin bad++; $display("FAIL rst_pre_ld: got %b want 0", ld_); end
    #2 rst = 1'b1;
    #1;
    total++; if (ld_ !== 1'b1) begin bad++; $display("FAIL rst_async_ld: got %b want 1", ld_); end
    total++; if (D !== 4'b0000) begin bad++; $display("FAIL rst_async_D: got %b want 0000", D); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_async_state: got %0d want 0", state); end
    total++; if (u_ !== 1'b0) begin bad++; $display("FAIL rst_async_u: got %b want 0", u_); end
    #2 rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 12) set_btns(1'b0, 1'b0, 1'b0);
      if (ld_ === 1'b0) begin
        lows++;
        if (first < 0) first = c;
      end
    end
    total++; if (lows != 1) begin bad++; $display("FAIL held_pulses: got %0d want 1", lows); end
    total++; if (first != DB + 3) begin bad++; $display("FAIL held_latency: got %0d want %0d", first, DB + 3); end
    total++; if (D !== 4'b1111) begin bad++; $display("FAIL held_D: got %b want 1111", D); end
  endtask

  task automatic test_rco();
    logic exp_u;
`ifdef COUNTER_CTRL_AUTO_REVERSE_EN
    exp_u = 1'b1;
`else
    exp_u = 1'b0;
`endif
    press(1'b0, 1'b1, 1'b0, 8);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL rco_pre_run: got %0d want 1", state); end
    total++; if (u_ !== 1'b0) begin bad++; $display("FAIL rco_pre_u: got %b want 0", u_); end
    rco_ = 1'b0;
    step();
    rco_ = 1'b1;
    total++; if (u_ !== exp_u) begin bad++; $display("FAIL rco_next: got %b want %b", u_, exp_u); end
    step();
    total++; if (u_ !== exp_u) begin bad++; $display("FAIL rco_settled: got %b want %b", u_, exp_u); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_dir();
    test_load_run_same();
    test_rst_mid_load();
    test_rco();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: DB_CYCLES, 4, consecutive stable cycles for a debounced button change (range 2..1023).
REQ-002 cp  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 btn_load  input  1  raw load button, active-high, asynchronous to cp.
REQ-005 btn_run  input  1  raw run/pause button, active-high, asynchronous.
REQ-006 btn_dir  input  1  raw direction button, active-high, asynchronous.
REQ-007 sw  input  4  preset switches, sampled only on an accepted load press.
REQ-008 rco_  input  1  ripple-carry from the downstream reversible counter, active-low.
REQ-009 ld_  output  1  counter parallel-load, active-low.
REQ-010 ct_  output  1  counter enable, active-low.
REQ-011 u_  output  1  direction: 0 = count up, 1 = count down.
REQ-012 D  output  4  preset data to counter.
REQ-013 state  output  2  current FSM state encoding, for display/debug.

Function
REQ-014 Each button SHALL pass a 2-FF synchronizer, then a stability counter; debounced level SHALL change only after DB_CYCLES consecutive identical synchronized samples.
REQ-015 A press SHALL be a one-cycle pulse on the debounced 0->1 edge; release SHALL produce nothing; a held button SHALL produce exactly one pulse.
REQ-016 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, LOAD=3.
REQ-017 Load press in any state SHALL go to LOAD for exactly one cycle, latch sw into D the same edge, then go to IDLE.
REQ-018 In LOAD: ld_=0, ct_=1; in all other states ld_=1.
REQ-019 Run press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; ignored while in LOAD.
REQ-020 ct_=0 only in RUN; ct_=1 in IDLE, PAUSE, LOAD.
REQ-021 Dir press SHALL toggle u_ in any state, one cycle after the press pulse.
REQ-022 Simultaneous load and run presses: load wins, run press discarded; dir press still applied.
REQ-023 D SHALL hold its value until the next accepted load; sw changes otherwise have no effect.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 While rst=1: state=IDLE, ld_=1, ct_=1, u_=0, D=4'b0000, synchronizers, stability counters and debounced levels cleared, immediately and independent of cp.
REQ-026 rst asserted during LOAD SHALL release ld_ to 1 without waiting for a clock edge.
REQ-027 After rst deasserts, a button already held SHALL produce one press after DB_CYCLES+2 cycles.

Configuration
REQ-028 Macro COUNTER_CTRL_AUTO_REVERSE_EN defined: in RUN, a registered falling edge of rco_ SHALL toggle u_ on the next cycle; if a dir press falls on the same cycle, u_ SHALL toggle once only.
REQ-029 Macro undefined: rco_ SHALL be ignored (port retained); u_ changes only on dir press or reset.

Structure
REQ-030 Package counter_ctrl_pkg SHALL hold the state typedef/encodings and the DB_CYCLES default constant.
REQ-031 Sub-module btn_debounce (synchronizer + stability counter + edge pulse) SHALL be instantiated three times.

Verification
REQ-032 Reset then btn_load high 10 cycles with sw=4'b0101 -> exactly one ld_=0 cycle, D=0101, state returns to IDLE, ct_=1.
REQ-033 btn_run glitch shorter than DB_CYCLES -> no state change; clean press -> RUN, ct_=0; second press -> PAUSE, ct_=1; third -> RUN.
REQ-034 btn_dir press during RUN -> u_ 0->1, ct_ stays 0; second press -> u_=0.
REQ-035 btn_load and btn_run pressed in the same cycle from IDLE -> LOAD then IDLE, not RUN.
REQ-036 rst pulsed mid-LOAD (between clock edges) -> ld_=1 and D=0000 before the next edge.
REQ-037 With COUNTER_CTRL_AUTO_REVERSE_EN, RUN, u_=0, rco_ driven low one cycle -> u_=1 next cycle; without macro -> u_ unchanged.
